zoom_out_controlador: RTL and testbench
=======================================

// Module: zoom_out_controlador
// PURPOSE
//  Sequencer for block-average zoom-out (2x: 2x2 blocks, 4x: 4x4 blocks).
//  Walks every output pixel in raster order and reads its source block from the frame RAM, one pixel per cycle.
//  Accumulates the block, divides by the pixel count, and writes the mean to the output RAM.
//  Sits between the command interface (start/fator_zoom) and the source/destination frame buffers.
// PARAMETERS
//  LARG_IN  320  source image width in pixels; must be a multiple of 4
//  ALT_IN   240  source image height in pixels; must be a multiple of 4
//  DATA_W   8    pixel width (grayscale)
//  ADDR_W   17   RAM address width; must satisfy LARG_IN*ALT_IN <= 2**ADDR_W
//  RD_LAT   2    source RAM read latency in cycles; must be >= 1
// PORTS
//  clk         in   1       system clock, rising edge
//  reset_n     in   1       asynchronous active-low reset
//  start       in   1       one-cycle pulse; starts one full frame
//  fator_zoom  in   2       01=2x, 10=4x; sampled on an accepted start
//  busy        out  1       high from the cycle after start is accepted until done
//  done        out  1       one-cycle pulse at end of frame
//  erro        out  1       one-cycle pulse together with done when fator_zoom was invalid
//  rd_en       out  1       source read request
//  rd_addr     out  ADDR_W  source address = y*LARG_IN + x
//  rd_data     in   DATA_W  source data, valid RD_LAT cycles after rd_en
//  wr_en       out  1       destination write strobe
//  wr_addr     out  ADDR_W  linear output index, 0..(LARG_IN/F)*(ALT_IN/F)-1
//  wr_data     out  DATA_W  block mean
// BEHAVIOUR
//  Reset (async, any state): state=OCIOSO; busy, done, erro, rd_en, wr_en = 0; addresses = 0; accumulator = 0.
//    In-flight read returns are discarded.
//  FSM states:
//   OCIOSO -> LER on start with fator 01/10.
//   OCIOSO -> FIM on start with fator 00/11: erro=1, no reads and no writes.
//   LER: issue N reads back-to-back (N=4 for 2x, 16 for 4x), one rd_en per cycle, block index k=0..N-1.
//        Block coords for 2x use indices {0,1,4,5}; for 4x, indices 0..15.
//   ESPERA: hold RD_LAT cycles until the last read data returns.
//   ESCREVE: one cycle wr_en=1; wr_data = soma>>2 (2x) or soma>>4 (4x), truncating; wr_addr then increments.
//        Then go to LER for the next output pixel, or to FIM after the last one.
//   FIM: done=1 for 1 cycle, busy=0, then OCIOSO.
//  Accumulation: a shift register of depth RD_LAT delays rd_en.
//    soma += rd_data when the delayed strobe is high; soma is cleared on entry to LER.
//    soma width = DATA_W+4 bits, so overflow is impossible.
//  Output raster: x_out 0..LARG_IN/F-1 inner, y_out 0..ALT_IN/F-1 outer.
//    Both counters wrap to 0 and do not carry past the frame end.
//  Throughput per output pixel: N + RD_LAT + 1 cycles. rd_en and wr_en are never high in the same cycle.
//  start while busy: ignored, with no effect on state or the latched fator.
//  fator_zoom changes mid-frame: no effect; the value latched at start is used.
//  A start pulse in the same cycle as done is ignored; it is accepted from OCIOSO only.
// STRUCTURE
//  Shared package: FATOR_2X=2'b01, FATOR_4X=2'b10, state encoding (OCIOSO, LER, ESPERA, ESCREVE, FIM).
//  Instantiate zoom_out_media_blocos (x_out, y_out, latched fator) for block coordinates.
//  A 16:1 mux on index k selects (x,y); rd_addr = y*LARG_IN + x.
//  Constant multiply: shift-add when LARG_IN is fixed, registered if timing requires.
//  No further sub-modules.
// TESTING (LARG_IN=8, ALT_IN=4, RD_LAT=2, behavioural RAM model)
//  1. Source all pixels = 8'd100, 2x -> 8 writes, wr_addr 0..7, each wr_data=100; one done pulse.
//     Cycles start->done = 8*(4+2+1) + overhead.
//  2. Source pixel = index (0..31), 4x -> 2 writes:
//     wr_data[0] = (0+1+2+3+8+...+27)/16 = 13; wr_data[1] = 17.
//  3. Block {255,255,255,254}, 2x -> wr_data = 1019>>2 = 254 (truncation, no overflow).
//  4. start with fator_zoom=2'b00 -> done=erro=1 for one cycle, zero rd_en, zero wr_en.
//  5. Second start pulse mid-frame, and fator_zoom toggled mid-frame -> output identical to test 1.
//  6. reset_n low during ESPERA -> all outputs 0 in the same cycle; a fresh start rewrites the frame correctly.

Source files
------------

// File: rtl/zoom_out_controlador_pkg.sv
// Shared definitions for the block-average zoom-out sequencer: zoom codes and FSM encoding.
package zoom_out_controlador_pkg;

  localparam logic [1:0] FATOR_2X = 2'b01;
  localparam logic [1:0] FATOR_4X = 2'b10;

  typedef enum logic [2:0] {
    OCIOSO,
    LER,
    ESPERA,
    ESCREVE,
    FIM
  } estado_t;

  function automatic logic fator_valido(input logic [1:0] fator);
    return (fator == FATOR_2X) || (fator == FATOR_4X);
  endfunction

endpackage

// File: rtl/zoom_out_media_blocos.sv
// Source-pixel coordinates of every position of a 4x4 window anchored at the current output pixel.
module zoom_out_media_blocos
  import zoom_out_controlador_pkg::*;
#(
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 8
) (
  input  logic [XW-1:0] x_out,
  input  logic [YW-1:0] y_out,
  input  logic [1:0]    fator,
  output logic [XW-1:0] x_bloco [16],
  output logic [YW-1:0] y_bloco [16]
);

  logic [XW-1:0] base_x;
  logic [YW-1:0] base_y;

  // Index i maps to (i%4, i/4); in 2x mode only {0,1,4,5} are ever selected.
  always_comb begin
    base_x = (fator == FATOR_4X) ? (x_out << 2) : (x_out << 1);
    base_y = (fator == FATOR_4X) ? (y_out << 2) : (y_out << 1);
    for (int i = 0; i < 16; i++) begin
      x_bloco[i] = base_x + XW'(i % 4);
      y_bloco[i] = base_y + YW'(i / 4);
    end
  end

endmodule

// File: rtl/zoom_out_controlador.sv
// Block-average zoom-out sequencer: reads each 2x2/4x4 source block, writes its mean to the output RAM.
module zoom_out_controlador
  import zoom_out_controlador_pkg::*;
#(
  parameter int unsigned LARG_IN = 320,
  parameter int unsigned ALT_IN  = 240,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        fator_zoom,
  output logic              busy,
  output logic              done,
  output logic              erro,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int unsigned XW = $clog2(LARG_IN);
  localparam int unsigned YW = $clog2(ALT_IN);
  localparam int unsigned EW = $clog2(RD_LAT) + 1;
  localparam int unsigned SW = DATA_W + 4;

  localparam logic [XW-1:0] XMAX_2X = XW'(LARG_IN / 2 - 1);
  localparam logic [XW-1:0] XMAX_4X = XW'(LARG_IN / 4 - 1);
  localparam logic [YW-1:0] YMAX_2X = YW'(ALT_IN / 2 - 1);
  localparam logic [YW-1:0] YMAX_4X = YW'(ALT_IN / 4 - 1);

  estado_t           estado_q, estado_d;
  logic [1:0]        fator_q, fator_d;
  logic [3:0]        k_q, k_d;
  logic [EW-1:0]     espera_q, espera_d;
  logic [XW-1:0]     x_out_q, x_out_d;
  logic [YW-1:0]     y_out_q, y_out_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [SW-1:0]     soma_q, soma_d;
  logic [RD_LAT-1:0] strobe_q;

  logic          fator_4x;
  logic [3:0]    k_ultimo;
  logic [XW-1:0] x_max;
  logic [YW-1:0] y_max;
  logic [3:0]    idx;
  logic [XW-1:0] x_bloco [16];
  logic [YW-1:0] y_bloco [16];
  logic [XW-1:0] x_sel;
  logic [YW-1:0] y_sel;

  assign fator_4x = (fator_q == FATOR_4X);
  assign k_ultimo = fator_4x ? 4'd15 : 4'd3;
  assign x_max    = fator_4x ? XMAX_4X : XMAX_2X;
  assign y_max    = fator_4x ? YMAX_4X : YMAX_2X;

  zoom_out_media_blocos #(
    .XW (XW),
    .YW (YW)
  ) u_media_blocos (
    .x_out   (x_out_q),
    .y_out   (y_out_q),
    .fator   (fator_q),
    .x_bloco (x_bloco),
    .y_bloco (y_bloco)
  );

  // 2x walks window indices 0,1,4,5 so it shares the 4x coordinate table.
  assign idx   = fator_4x ? k_q : {1'b0, k_q[1], 1'b0, k_q[0]};
  assign x_sel = x_bloco[idx];
  assign y_sel = y_bloco[idx];

  always_comb begin
    estado_d  = estado_q;
    fator_d   = fator_q;
    k_d       = k_q;
    espera_d  = espera_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    wr_addr_d = wr_addr_q;
    soma_d    = soma_q;

    if (strobe_q[RD_LAT-1]) begin
      soma_d = soma_q + SW'(rd_data);
    end

    unique case (estado_q)
      OCIOSO: begin
        if (start) begin
          fator_d = fator_zoom;
          if (fator_valido(fator_zoom)) begin
            estado_d  = LER;
            k_d       = '0;
            x_out_d   = '0;
            y_out_d   = '0;
            wr_addr_d = '0;
            soma_d    = '0;
          end else begin
            estado_d = FIM;
          end
        end
      end
      LER: begin
        if (k_q == k_ultimo) begin
          k_d      = '0;
          espera_d = '0;
          estado_d = ESPERA;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ESPERA: begin
        espera_d = espera_q + EW'(1);
        if (espera_q == EW'(RD_LAT - 1)) begin
          estado_d = ESCREVE;
        end
      end
      ESCREVE: begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        soma_d    = '0;
        estado_d  = LER;
        if (x_out_q == x_max) begin
          x_out_d = '0;
          if (y_out_q == y_max) begin
            y_out_d   = '0;
            wr_addr_d = '0;
            estado_d  = FIM;
          end else begin
            y_out_d = y_out_q + YW'(1);
          end
        end else begin
          x_out_d = x_out_q + XW'(1);
        end
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q  <= OCIOSO;
      fator_q   <= '0;
      k_q       <= '0;
      espera_q  <= '0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      wr_addr_q <= '0;
      soma_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      fator_q   <= fator_d;
      k_q       <= k_d;
      espera_q  <= espera_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      wr_addr_q <= wr_addr_d;
      soma_q    <= soma_d;
    end
  end

  // Read-strobe delay line; clearing it on reset drops any returns still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= '0;
    end else begin
      strobe_q[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        strobe_q[i] <= strobe_q[i-1];
      end
    end
  end

  assign busy  = (estado_q == LER) || (estado_q == ESPERA) || (estado_q == ESCREVE);
  assign done  = (estado_q == FIM);
  assign erro  = (estado_q == FIM) && !fator_valido(fator_q);
  assign rd_en = (estado_q == LER);
  assign wr_en = (estado_q == ESCREVE);

  // Constant multiply by LARG_IN; synthesis reduces it to shift-add.
  assign rd_addr = rd_en ? (ADDR_W'(y_sel) * ADDR_W'(LARG_IN) + ADDR_W'(x_sel)) : '0;
  assign wr_addr = wr_addr_q;
  assign wr_data = fator_4x ? DATA_W'(soma_q >> 4) : DATA_W'(soma_q >> 2);

endmodule

// File: tb/tb_zoom_out_controlador.sv
// Randomized bench for zoom_out_controlador: behavioural source RAM plus a block-mean reference model.
module tb_zoom_out_controlador;

  localparam int W      = 8;
  localparam int H      = 4;
  localparam int NPIX   = W * H;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  fator_zoom;
  logic        busy, done, erro, rd_en, wr_en;
  logic [16:0] rd_addr, wr_addr;
  logic [7:0]  rd_data, wr_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [NPIX];
  logic [7:0] lat [RD_LAT];

  int unsigned n_rd = 0, n_overlap = 0, n_done = 0, n_erro = 0, n_erro_sozinho = 0, n_busy = 0;
  logic [16:0] log_addr [$];
  logic [7:0]  log_data [$];

  zoom_out_controlador #(
    .LARG_IN (W),
    .ALT_IN  (H),
    .DATA_W  (8),
    .ADDR_W  (17),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .fator_zoom (fator_zoom),
    .busy       (busy),
    .done       (done),
    .erro       (erro),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  // Source RAM: data for a request appears RD_LAT cycles later.
  always @(posedge clk) begin
    lat[0] <= (rd_en && rd_addr < 17'(NPIX)) ? mem[rd_addr[4:0]] : 8'hxx;
    for (int i = 1; i < RD_LAT; i++) lat[i] <= lat[i-1];
  end
  assign rd_data = lat[RD_LAT-1];

  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        log_addr.push_back(wr_addr);
        log_data.push_back(wr_data);
      end
      if (rd_en) n_rd++;
      if (rd_en && wr_en) n_overlap++;
      if (done) n_done++;
      if (erro) n_erro++;
      if (erro && !done) n_erro_sozinho++;
      if (busy) n_busy++;
    end
  end

  // Mean of the FxF source block behind output pixel idx.
  function automatic logic [7:0] media_ref(input int idx, input logic [1:0] f);
    int fz, wo, xo, yo, soma;
    fz = (f == 2'b10) ? 4 : 2;
    wo = W / fz;
    xo = idx % wo;
    yo = idx / wo;
    soma = 0;
    for (int dy = 0; dy < fz; dy++)
      for (int dx = 0; dx < fz; dx++)
        soma += int'(mem[(yo * fz + dy) * W + xo * fz + dx]);
    return 8'(soma / (fz * fz));
  endfunction

  task automatic enche_const(input logic [7:0] v);
    for (int i = 0; i < NPIX; i++) mem[i] = v;
  endtask

  task automatic enche_indice();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
  endtask

  task automatic enche_saturado();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(254, 255));
    mem[0] = 8'd255;
    mem[1] = 8'd255;
    mem[W] = 8'd255;
    mem[W + 1] = 8'd254;
  endtask

  task automatic enche_aleatorio();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
  endtask

  // Start one frame and wait for done; ciclos = -1 if done never came.
  task automatic roda_quadro(input logic [1:0] f, input bit perturba, output int ciclos);
    @(negedge clk);
    start = 1'b1;
    fator_zoom = f;
    ciclos = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      start = perturba && (c == 20 || c == 35);
      if (perturba) fator_zoom = 2'($urandom);
      if (done) begin
        ciclos = c;
        break;
      end
    end
    start = 1'b0;
    fator_zoom = f;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    fator_zoom = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, erro, rd_en, wr_en, rd_addr, wr_addr, wr_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b erro=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d wr_data=%0d, expected all 0",
               busy, done, erro, rd_en, wr_en, rd_addr, wr_addr, wr_data);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, rd_en, wr_en} !== 4'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b done=%b rd_en=%b wr_en=%b, expected 0",
               busy, done, rd_en, wr_en);
    end
  endtask

  task automatic test_quadro(input string nome, input logic [1:0] f, input bit perturba);
    int ciclos, npix, nblk, b_wr, b_rd, b_ov, b_done, b_erro, b_busy, esp;
    npix = (f == 2'b10) ? NPIX / 16 : NPIX / 4;
    nblk = (f == 2'b10) ? 16 : 4;
    esp  = npix * (nblk + RD_LAT + 1);
    b_wr = log_addr.size();
    b_rd = n_rd; b_ov = n_overlap; b_done = n_done; b_erro = n_erro; b_busy = n_busy;
    roda_quadro(f, perturba, ciclos);
    n_cmp++;
    if (ciclos !== esp + 1) begin
      n_err++;
      $display("FAIL %s cycles start->done: got %0d expected %0d", nome, ciclos, esp + 1);
    end
    n_cmp++;
    if (log_addr.size() - b_wr !== npix) begin
      n_err++;
      $display("FAIL %s write_count: got %0d expected %0d", nome, log_addr.size() - b_wr, npix);
    end
    for (int i = 0; i < npix && b_wr + i < log_addr.size(); i++) begin
      n_cmp++;
      if (log_addr[b_wr + i] !== 17'(i)) begin
        n_err++;
        $display("FAIL %s wr_addr[%0d]: got %0d expected %0d", nome, i, log_addr[b_wr + i], i);
      end
      n_cmp++;
      if (log_data[b_wr + i] !== media_ref(i, f)) begin
        n_err++;
        $display("FAIL %s wr_data[%0d]: got %0d expected %0d", nome, i, log_data[b_wr + i],
                 media_ref(i, f));
      end
    end
    n_cmp++;
    if (n_rd - b_rd !== npix * nblk) begin
      n_err++;
      $display("FAIL %s read_count: got %0d expected %0d", nome, n_rd - b_rd, npix * nblk);
    end
    n_cmp++;
    if (n_overlap - b_ov !== 0) begin
      n_err++;
      $display("FAIL %s rd_wr_overlap: got %0d expected 0", nome, n_overlap - b_ov);
    end
    n_cmp++;
    if (n_done - b_done !== 1 || n_erro - b_erro !== 0) begin
      n_err++;
      $display("FAIL %s done/erro pulses: got %0d/%0d expected 1/0", nome, n_done - b_done,
               n_erro - b_erro);
    end
    n_cmp++;
    if (n_busy - b_busy !== esp) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", nome, n_busy - b_busy, esp);
    end
  endtask

  task automatic test_fator_invalido();
    logic [1:0] fs [2];
    int ciclos, b_wr, b_rd, b_done, b_erro, b_so, b_busy;
    fs[0] = 2'b00;
    fs[1] = 2'b11;
    for (int j = 0; j < 2; j++) begin
      b_wr = log_addr.size();
      b_rd = n_rd; b_done = n_done; b_erro = n_erro; b_so = n_erro_sozinho; b_busy = n_busy;
      roda_quadro(fs[j], 1'b0, ciclos);
      n_cmp++;
      if (ciclos !== 1) begin
        n_err++;
        $display("FAIL invalid_%b cycles: got %0d expected 1", fs[j], ciclos);
      end
      n_cmp++;
      if (n_done - b_done !== 1 || n_erro - b_erro !== 1 || n_erro_sozinho - b_so !== 0) begin
        n_err++;
        $display("FAIL invalid_%b pulses: got done=%0d erro=%0d erro_alone=%0d expected 1/1/0",
                 fs[j], n_done - b_done, n_erro - b_erro, n_erro_sozinho - b_so);
      end
      n_cmp++;
      if (n_rd - b_rd !== 0 || log_addr.size() - b_wr !== 0 || n_busy - b_busy !== 0) begin
        n_err++;
        $display("FAIL invalid_%b activity: got rd=%0d wr=%0d busy=%0d expected 0/0/0", fs[j],
                 n_rd - b_rd, log_addr.size() - b_wr, n_busy - b_busy);
      end
    end
  endtask

  task automatic test_reset_em_espera();
    bit achou;
    enche_aleatorio();
    @(negedge clk);
    start = 1'b1;
    fator_zoom = 2'b01;
    achou = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && !rd_en && !wr_en) begin
        achou = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!achou) begin
      n_err++;
      $display("FAIL wait_state_reached: got none within 100 cycles, expected a read-wait cycle");
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, erro, rd_en, wr_en, rd_addr, wr_addr, wr_data} !== '0) begin
      n_err++;
      $display("FAIL async_reset_outputs: got busy=%b done=%b erro=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d wr_data=%0d, expected all 0",
               busy, done, erro, rd_en, wr_en, rd_addr, wr_addr, wr_data);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit achou;
    int b_rd;
    @(negedge clk);
    start = 1'b1;
    fator_zoom = 2'b01;
    achou = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        achou = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!achou) begin
      n_err++;
      $display("FAIL b2b_done_seen: got no done within 200 cycles, expected done");
    end
    start = 1'b1;  // coincides with the done cycle, must be ignored
    b_rd = n_rd;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done_width: got done=%b one cycle later, expected 0", done);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || n_rd - b_rd !== 0) begin
      n_err++;
      $display("FAIL b2b_start_on_done_ignored: got busy=%b reads=%0d, expected 0/0", busy,
               n_rd - b_rd);
    end
  endtask

  initial begin
    test_reset();
    enche_const(8'd100);
    test_quadro("const_2x", 2'b01, 1'b0);
    enche_indice();
    test_quadro("index_4x", 2'b10, 1'b0);
    enche_saturado();
    test_quadro("trunc_2x", 2'b01, 1'b0);
    test_fator_invalido();
    enche_aleatorio();
    test_quadro("midframe_2x", 2'b01, 1'b1);
    test_reset_em_espera();
    test_quadro("after_reset_2x", 2'b01, 1'b0);
    test_back_to_back();
    test_quadro("after_done_2x", 2'b01, 1'b0);
    for (int r = 0; r < 4; r++) begin
      enche_aleatorio();
      test_quadro("random", ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
